// File: rtl/axis_spi_arbiter_if.sv
// Stream bundle between the SPI arbiter and its requesters / shared SPI master.
// The master modport is the arbiter side and the slave modport is the environment side.
interface axis_spi_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 8
);
  // requester MOSI streams
  logic [NUM_REQ-1:0]       req_tvalid;
  logic [NUM_REQ-1:0]       req_tready;
  logic [NUM_REQ-1:0]       req_tlast;
  logic [NUM_REQ-1:0]       req_tkeep;
  logic [NUM_REQ*WIDTH-1:0] req_tdata;
  // response streams back to requesters (shared data bus)
  logic [NUM_REQ-1:0]       rsp_tvalid;
  logic [NUM_REQ-1:0]       rsp_tready;
  logic [NUM_REQ-1:0]       rsp_tlast;
  logic [NUM_REQ-1:0]       rsp_tkeep;
  logic [WIDTH-1:0]         rsp_tdata;
  // stream into the SPI master
  logic                     mosi_tvalid;
  logic                     mosi_tready;
  logic                     mosi_tlast;
  logic                     mosi_tkeep;
  logic [WIDTH-1:0]         mosi_tdata;
  // stream out of the SPI master
  logic                     miso_tvalid;
  logic                     miso_tready;
  logic [WIDTH-1:0]         miso_tdata;

  modport master (
    input  req_tvalid, req_tlast, req_tkeep, req_tdata,
    output req_tready,
    output rsp_tvalid, rsp_tlast, rsp_tkeep, rsp_tdata,
    input  rsp_tready,
    output mosi_tvalid, mosi_tlast, mosi_tkeep, mosi_tdata,
    input  mosi_tready,
    input  miso_tvalid, miso_tdata,
    output miso_tready
  );

  modport slave (
    output req_tvalid, req_tlast, req_tkeep, req_tdata,
    input  req_tready,
    input  rsp_tvalid, rsp_tlast, rsp_tkeep, rsp_tdata,
    output rsp_tready,
    input  mosi_tvalid, mosi_tlast, mosi_tkeep, mosi_tdata,
    output mosi_tready,
    output miso_tvalid, miso_tdata,
    input  miso_tready
  );
endinterface

// File: rtl/axis_spi_arbiter.sv
// axis_spi_arbiter: shares one SPI master between NUM_REQ AXI4-Stream requesters.
// One packet = one SPI transaction; the grant is held until every response byte
// for that packet has been delivered back to the owner.
// Build option: define AXIS_SPI_ARB_PRIORITY_EN for fixed lowest-index-wins
// priority; otherwise arbitration is round-robin.
module axis_spi_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 8,
  parameter int MAX_OUT = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  axis_spi_arbiter_if.master   bus,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 stray_o
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]         state_r;
  logic [NUM_REQ-1:0] grant_r;
  logic [CW-1:0]      cnt_r;
  logic [CW-1:0]      cnt_nxt_s;
  logic               stray_r;
  logic [IW-1:0]      gidx_s;
  logic [IW-1:0]      win_idx_s;
  logic [NUM_REQ-1:0] win_oh_s;
  logic               win_any_s;
  logic               send_s;
  logic               drain_s;
  logic               can_send_s;
  logic               fwd_s;
  logic               mosi_hs_s;
  logic               miso_dec_s;
  logic               stray_s;

  assign grant_o = grant_r;
  assign busy_o  = (state_r != ST_IDLE);
  assign stray_o = stray_r;

  // Binary index of the one-hot grant, used to steer the muxes.
  always_comb begin
    gidx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gidx_s = grant_r[i] ? IW'(i) : gidx_s;
    end
  end

`ifdef AXIS_SPI_ARB_PRIORITY_EN
  // Fixed priority: the lowest-index valid requester wins.
  always_comb begin
    win_idx_s = '0;
    win_any_s = |bus.req_tvalid;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      win_idx_s = bus.req_tvalid[i] ? IW'(i) : win_idx_s;
    end
  end
`else
  logic [IW-1:0] last_r;
  logic [IW-1:0] cand_s;
  logic          hit_s;

  // Round-robin: search upward from the requester after the last winner.
  always_comb begin
    win_idx_s = '0;
    win_any_s = 1'b0;
    cand_s    = '0;
    hit_s     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s    = IW'((int'(last_r) + 1 + k) % NUM_REQ);
      hit_s     = !win_any_s && bus.req_tvalid[cand_s];
      win_idx_s = hit_s ? cand_s : win_idx_s;
      win_any_s = win_any_s | hit_s;
    end
  end

  // Last-winner pointer; after reset the search starts at requester 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_r <= IW'(NUM_REQ - 1);
    end else if (state_r == ST_IDLE && win_any_s) begin
      last_r <= win_idx_s;
    end else begin
      last_r <= last_r;
    end
  end
`endif

  assign win_oh_s = NUM_REQ'(1) << win_idx_s;

  // Pass-through steering of the granted requester onto the master streams.
  always_comb begin
    send_s     = (state_r == ST_SEND);
    drain_s    = (state_r == ST_DRAIN);
    can_send_s = (cnt_r < CNT_MAX);
    // A MISO byte is only forwarded while a packet owns bytes in flight.
    fwd_s      = (send_s || drain_s) && (cnt_r != '0);

    bus.req_tready = '0;
    bus.rsp_tvalid = '0;
    bus.rsp_tlast  = '0;
    bus.rsp_tkeep  = '1;
    bus.rsp_tdata  = bus.miso_tdata;

    bus.mosi_tdata  = bus.req_tdata[int'(gidx_s)*WIDTH +: WIDTH];
    bus.mosi_tlast  = bus.req_tlast[gidx_s];
    bus.mosi_tkeep  = bus.req_tkeep[gidx_s];
    bus.mosi_tvalid = send_s && can_send_s && bus.req_tvalid[gidx_s];
    bus.req_tready[gidx_s] = send_s && can_send_s && bus.mosi_tready;

    bus.miso_tready = fwd_s ? bus.rsp_tready[gidx_s] : 1'b1;
    bus.rsp_tvalid[gidx_s] = fwd_s && bus.miso_tvalid;
    bus.rsp_tlast[gidx_s]  = fwd_s && drain_s && (cnt_r == CNT_ONE);

    mosi_hs_s  = bus.mosi_tvalid && bus.mosi_tready;
    miso_dec_s = fwd_s && bus.miso_tvalid && bus.rsp_tready[gidx_s];
    // Unowned bytes are always accepted and dropped.
    stray_s    = bus.miso_tvalid && !fwd_s;
  end

  // Outstanding-byte counter update; simultaneous send and return cancel out.
  always_comb begin
    case ({mosi_hs_s, miso_dec_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
      2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Packet FSM: grant, send until tlast, drain responses, release.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      grant_r <= '0;
      cnt_r   <= '0;
      stray_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      stray_r <= stray_s;
      case (state_r)
        ST_IDLE: begin
          if (win_any_s) begin
            grant_r <= win_oh_s;
            state_r <= ST_SEND;
          end else begin
            grant_r <= '0;
            state_r <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (mosi_hs_s && bus.mosi_tlast) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_SEND;
          end
        end
        ST_DRAIN: begin
          if (cnt_nxt_s == '0) begin
            grant_r <= '0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          grant_r <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axis_spi_arbiter.md
# axis_spi_arbiter

Shares a single `axis_spi_master` between up to four AXI4-Stream requesters. Each requester packet (tvalid…tlast) is one SPI transaction with SSEL held across it. The arbiter grants one requester per packet and forwards its bytes to the master's MOSI stream. It routes the full-duplex MISO bytes returned by the master back to the granted requester, and releases the grant only when every response byte has been delivered.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, legal range 2..4.
- `WIDTH`, 8: byte width of all streams.
- `MAX_OUT`, 15: maximum bytes sent to the master but not yet answered; the counter is `$clog2(MAX_OUT+1)` bits.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `req_tvalid/req_tready/req_tlast/req_tkeep`  in/out/in/in  NUM_REQ each  requester MOSI streams.
- `req_tdata`  in  NUM_REQ*WIDTH  requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- `rsp_tvalid/rsp_tlast/rsp_tkeep`  out  NUM_REQ each  response streams to requesters.
- `rsp_tready`  in  NUM_REQ  response ready.
- `rsp_tdata`  out  WIDTH  response data, shared by all requesters; qualified by `rsp_tvalid[i]`.
- `mosi_tvalid/mosi_tlast/mosi_tkeep`  out  1  stream to master `s_t*`.
- `mosi_tready`  in  1.
- `mosi_tdata`  out  WIDTH.
- `miso_tvalid`  in  1  stream from master `m_t*`.
- `miso_tready`  out  1.
- `miso_tdata`  in  WIDTH; `miso_tlast` and `miso_tkeep` are ignored.
- `grant_o`  out  NUM_REQ  one-hot current grant.
- `busy_o`  out  1  high when the state is not IDLE.
- `stray_o`  out  1  one-cycle pulse when a MISO byte is discarded.

## Operation
- States: IDLE, SEND, DRAIN.
- **IDLE:**
  - If any `req_tvalid` is high, select a winner and register it into `grant_o`; next state is SEND.
  - Round-robin search starts at (last winner + 1) mod NUM_REQ. After reset the last winner is NUM_REQ-1, so requester 0 wins first.
  - `miso_tready` is 1; any MISO byte accepted in IDLE is discarded and pulses `stray_o`.
- **SEND:**
  - The granted requester's `req_t*` is passed combinationally to `mosi_t*`.
  - `mosi_tvalid = req_tvalid[g] && (cnt < MAX_OUT)`, and `req_tready[g] = mosi_tready && (cnt < MAX_OUT)`.
  - A MOSI handshake increments `cnt`. A MISO handshake decrements it. Both in the same cycle leave it unchanged.
  - A MOSI handshake with tlast moves the state to DRAIN.
- **DRAIN:** no MOSI traffic. When `cnt` reaches 0, `grant_o` is cleared and the state returns to IDLE.
- **Response path (SEND and DRAIN):**
  - `miso_tready = rsp_tready[g]`, `rsp_tvalid[g] = miso_tvalid`, `rsp_tdata = miso_tdata`, `rsp_tkeep = 1`.
  - `rsp_tlast[g]` is asserted only in DRAIN with `cnt == 1`.
  - All non-granted `req_tready`/`rsp_tvalid` are 0.
- **MISO with `cnt == 0` in SEND:** the byte is accepted but not forwarded, and `stray_o` pulses.
- **Reset (any state, including mid-packet):**
  - Outputs: state IDLE, `grant_o=0`, `cnt=0`, `busy_o=0`, `stray_o=0`, all `req_tready=0`, all `rsp_tvalid=0`, `mosi_tvalid=0`.
  - The round-robin pointer returns to NUM_REQ-1.
  - In-flight MISO bytes after reset are discarded via the IDLE rule.

## Timing
- Arbitration latency is 1 cycle: `req_tvalid` rising in cycle n (state IDLE) gives `grant_o` and `mosi_tvalid` in cycle n+1.
- Release: the DRAIN cycle where `cnt` reaches 0 is followed by IDLE. The next grant appears 2 cycles after the last response handshake, so there is at least one idle cycle between packets (this gap frames SSEL in the master).
- No registers sit in the data paths. The MOSI and MISO handshakes are zero-latency pass-throughs.
- Back-pressure: while `cnt == MAX_OUT`, `mosi_tvalid` stays 0 until a MISO handshake occurs.
- Simultaneous MOSI tlast and MISO handshake: `cnt` is unchanged and the state moves to DRAIN.

## Configuration
- `AXIS_SPI_ARB_PRIORITY_EN`:
  - Defined: fixed priority, where the lowest-index valid requester always wins and the round-robin pointer is not built.
  - Undefined (default): round-robin as described above.

## Test plan
- **Single requester:** req0 sends 3 bytes A1,A2,A3 (tlast on A3); master echoes 55,56,57.
  - `grant_o=01` from cycle 1.
  - rsp0 receives 55,56,57 with tlast on 57.
  - `grant_o=00` in the cycle after the 57 handshake.
- **Contention:** req0 and req1 are both valid from reset.
  - Round-robin: order is 0,1,0,1 over 4 one-byte packets.
  - With `AXIS_SPI_ARB_PRIORITY_EN`: order is 0,0,0,0 until req0 goes idle.
- **Back-pressure:** `MAX_OUT=2` and the master withholds MISO.
  - `mosi_tvalid` drops after 2 bytes.
  - It resumes one MOSI byte per returned MISO byte.
- **Response stall:** `rsp_tready[1]=0` for 5 cycles in DRAIN.
  - `miso_tready=0` for those 5 cycles.
  - `grant_o` is held; no data is lost.
- **Reset mid-packet:** reset in SEND after 1 of 4 bytes.
  - Next cycle: `grant_o=0`, `busy_o=0`, `cnt=0`.
  - A trailing MISO byte is accepted and pulses `stray_o` for one cycle.
- **Stray byte:** MISO byte injected in IDLE.
  - `stray_o=1` for one cycle.
  - No `rsp_tvalid` is asserted.
